// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions: register-file geometry, the zero register
// and the request record carried from a producer to the write port.
package wb_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus between the pipeline / long-latency producers and the write-back
// arbiter, including the registered register-file write port.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = wb_port_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = wb_port_arbiter_pkg::ADDR_W,
  parameter int LL_DEPTH = 2
);

  logic                             pipe_valid;
  logic [ADDR_W-1:0]                pipe_rd;
  logic [DATA_W-1:0]                pipe_data;
  logic                             pipe_stall;
  logic                             ll_valid;
  logic                             ll_ready;
  logic [ADDR_W-1:0]                ll_rd;
  logic [DATA_W-1:0]                ll_data;
  logic [$clog2(LL_DEPTH+1)-1:0]    ll_count;
  logic                             write_en;
  logic [ADDR_W-1:0]                wb_addr;
  logic [DATA_W-1:0]                wb_data;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    input  pipe_stall, ll_ready, ll_count, write_en, wb_addr, wb_data
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    output pipe_stall, ll_ready, ll_count, write_en, wb_addr, wb_data
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO holding long-latency results until the register
// file write port is free; occupancy is exported as a count.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: merges in-order pipeline results with buffered
// long-latency results onto the single register-file write port.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = wb_port_arbiter_pkg::DATA_W,
  parameter int ADDR_W   = wb_port_arbiter_pkg::ADDR_W,
  parameter int LL_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_port_arbiter_if.slave     bus
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic             pipe_req;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  wb_req_t          grant;

  assign pipe_req = bus.pipe_valid && (bus.pipe_rd != REG_ZERO);

  wb_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LL_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.ll_rd, bus.ll_data}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (bus.ll_count)
  );

  // A full FIFO outranks the pipeline so buffered results can never starve.
  always_comb begin
    grant          = '0;
    push           = 1'b0;
    pop            = 1'b0;
    bus.pipe_stall = 1'b0;
    bus.ll_ready   = !rst;
    if (full) begin
      grant          = {1'b1, head};
      pop            = 1'b1;
      bus.pipe_stall = pipe_req;
      bus.ll_ready   = 1'b0;
    end else if (pipe_req) begin
      grant = {1'b1, bus.pipe_rd, bus.pipe_data};
      push  = bus.ll_valid && (bus.ll_rd != REG_ZERO);
    end else if (!empty) begin
      grant = {1'b1, head};
      pop   = 1'b1;
      push  = bus.ll_valid && (bus.ll_rd != REG_ZERO);
    end else if (bus.ll_valid) begin
      grant = {(bus.ll_rd != REG_ZERO), bus.ll_rd, bus.ll_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.write_en <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
    end else begin
      bus.write_en <= grant.valid;
      if (grant.valid) begin
        bus.wb_addr <= grant.rd;
        bus.wb_data <= grant.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipeline, bypass, FIFO
// conflict/drain, zero-register discards and asynchronous reset.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   total_checks;
  int   bad_checks;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pdata;
    bus.ll_valid   = lv;
    bus.ll_rd      = lrd;
    bus.ll_data    = ldata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rst_we",    32'(bus.write_en), 32'd0);
    checkOutput("rst_addr",  32'(bus.wb_addr),  32'd0);
    checkOutput("rst_data",  bus.wb_data,       32'd0);
    checkOutput("rst_ready", 32'(bus.ll_ready), 32'd0);
    checkOutput("rst_count", 32'(bus.ll_count), 32'd0);
    #19;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.ll_ready),   32'd1);
    checkOutput("post_rst_stall", 32'(bus.pipe_stall), 32'd0);

    // pipeline-only write, then hold of address when idle
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("pipe_we",   32'(bus.write_en), 32'd1);
    checkOutput("pipe_addr", 32'(bus.wb_addr),  32'd5);
    checkOutput("pipe_data", bus.wb_data,       32'h1234);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("pipe_we_off",    32'(bus.write_en), 32'd0);
    checkOutput("pipe_addr_hold", 32'(bus.wb_addr),  32'd5);

    // long-latency bypass with empty FIFO
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
    checkOutput("byp_ready", 32'(bus.ll_ready), 32'd1);
    tick();
    checkOutput("byp_we",    32'(bus.write_en), 32'd1);
    checkOutput("byp_addr",  32'(bus.wb_addr),  32'd7);
    checkOutput("byp_data",  bus.wb_data,       32'hDEADBEEF);
    checkOutput("byp_count", 32'(bus.ll_count), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("byp_we_off", 32'(bus.write_en), 32'd0);

    // conflict: pipeline wins while ll results are buffered, then drain
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    tick();
    checkOutput("cf1_addr",  32'(bus.wb_addr),  32'd1);
    checkOutput("cf1_count", 32'(bus.ll_count), 32'd1);
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hA0);
    checkOutput("cf2_ready", 32'(bus.ll_ready), 32'd1);
    tick();
    checkOutput("cf2_addr",  32'(bus.wb_addr),  32'd2);
    checkOutput("cf2_count", 32'(bus.ll_count), 32'd2);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    checkOutput("cf3_stall", 32'(bus.pipe_stall), 32'd1);
    checkOutput("cf3_ready", 32'(bus.ll_ready),   32'd0);
    tick();
    checkOutput("drain9_we",    32'(bus.write_en), 32'd1);
    checkOutput("drain9_addr",  32'(bus.wb_addr),  32'd9);
    checkOutput("drain9_data",  bus.wb_data,       32'h99);
    checkOutput("drain9_count", 32'(bus.ll_count), 32'd1);
    checkOutput("drain9_stall", 32'(bus.pipe_stall), 32'd0);
    tick();
    checkOutput("pipe3_addr",  32'(bus.wb_addr),  32'd3);
    checkOutput("pipe3_data",  bus.wb_data,       32'h33);
    checkOutput("pipe3_count", 32'(bus.ll_count), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("drain10_we",    32'(bus.write_en), 32'd1);
    checkOutput("drain10_addr",  32'(bus.wb_addr),  32'd10);
    checkOutput("drain10_data",  bus.wb_data,       32'hA0);
    checkOutput("drain10_count", 32'(bus.ll_count), 32'd0);
    tick();
    checkOutput("drain_idle_we", 32'(bus.write_en), 32'd0);

    // zero-register results are consumed without writing
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    checkOutput("zero_stall", 32'(bus.pipe_stall), 32'd0);
    checkOutput("zero_ready", 32'(bus.ll_ready),   32'd1);
    tick();
    checkOutput("zero_we",    32'(bus.write_en), 32'd0);
    checkOutput("zero_count", 32'(bus.ll_count), 32'd0);
    checkOutput("zero_addr",  32'(bus.wb_addr),  32'd10);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // asynchronous reset with a full FIFO and a pending write
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    tick();
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hA0);
    tick();
    checkOutput("pre_arst_we",    32'(bus.write_en), 32'd1);
    checkOutput("pre_arst_count", 32'(bus.ll_count), 32'd2);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_we",    32'(bus.write_en), 32'd0);
    checkOutput("arst_addr",  32'(bus.wb_addr),  32'd0);
    checkOutput("arst_data",  bus.wb_data,       32'd0);
    checkOutput("arst_count", 32'(bus.ll_count), 32'd0);
    checkOutput("arst_ready", 32'(bus.ll_ready), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("post_arst_we",    32'(bus.write_en), 32'd0);
    checkOutput("post_arst_count", 32'(bus.ll_count), 32'd0);
    checkOutput("post_arst_ready", 32'(bus.ll_ready), 32'd1);
    tick();
    checkOutput("post_arst_we2",   32'(bus.write_en), 32'd0);
    checkOutput("post_arst_addr",  32'(bus.wb_addr),  32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
